// File: rtl/periph_arb_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM state encoding,
// master selector, and the memory-mapped region map of the peripheral bus.
package periph_arb_pkg;

    // Transaction FSM: every non-IDLE state lasts exactly one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Identifies one of the two bus masters.
    typedef enum logic {
        SEL_M0 = 1'b0,
        SEL_M1 = 1'b1
    } master_e;

    // Decoded peripheral region of an address.
    typedef enum logic [1:0] {
        REGION_OLED  = 2'd0,
        REGION_LED1  = 2'd1,
        REGION_LED2  = 2'd2,
        REGION_OTHER = 2'd3
    } region_e;

    // Region boundaries (inclusive lower bounds; REGION_END is the last mapped address).
    localparam logic [15:0] OLED_LO    = 16'hC000;
    localparam logic [15:0] OLED_HI    = 16'hC443;
    localparam logic [15:0] LED1_LO    = 16'hC444;
    localparam logic [15:0] LED2_LO    = 16'hC888;
    localparam logic [15:0] REGION_END = 16'hCCCB;

    // Map a 16-bit bus address onto the peripheral region it selects.
    function automatic region_e addr_region(input logic [15:0] addr);
        region_e region;
        region = REGION_OTHER;
        if (addr >= OLED_LO && addr <= OLED_HI) begin
            region = REGION_OLED;
        end else if (addr >= LED1_LO && addr < LED2_LO) begin
            region = REGION_LED1;
        end else if (addr >= LED2_LO && addr <= REGION_END) begin
            region = REGION_LED2;
        end
        return region;
    endfunction

endpackage

// File: rtl/periph_arb_holdoff.sv
// OLED write holdoff timer. A load arms the counter with HOLDOFF_CYCLES; it then
// counts down once per cycle and saturates at zero. busy is high while nonzero.
// Only instantiated when PERIPH_ARB_OLED_HOLDOFF_EN is defined.
module periph_arb_holdoff #(
    parameter int HOLDOFF_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    localparam int CNT_W = $clog2(HOLDOFF_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Load has priority over the countdown so a back-to-back OLED write re-arms the full spacing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(HOLDOFF_CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-cycle peripheral bus.
// Each granted access runs IDLE -> ISSUE -> WAIT -> DONE, one cycle per state,
// so done follows gnt by exactly three cycles and the bus sustains one access
// every four cycles.
// Optional feature: define PERIPH_ARB_OLED_HOLDOFF_EN to enforce a minimum spacing
// of HOLDOFF_CYCLES between writes into the OLED window (0xC000..0xC443).
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int HOLDOFF_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_done,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic [ADDR_WIDTH-1:0] p_write_addr,
    output logic [ADDR_WIDTH-1:0] p_read_addr,
    output logic                  p_we,
    output logic                  p_re,
    output logic                  p_en,
    input  logic [DATA_WIDTH-1:0] p_q
);

    arb_state_e state;
    master_e    last_gnt;   // master granted most recently
    master_e    cur_sel;    // master owning the transaction in flight
    logic       cur_we;     // latched direction of the transaction in flight

    logic       m0_elig;
    logic       m1_elig;
    logic       grant_any;
    master_e    grant_sel;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef PERIPH_ARB_OLED_HOLDOFF_EN
    logic holdoff_busy;
    logic holdoff_load;
    logic m0_oled_wr;
    logic m1_oled_wr;

    // The region map is 16 bits wide; other address widths are resized onto it.
    assign m0_oled_wr = m0_we && (addr_region(16'(m0_addr)) == REGION_OLED);
    assign m1_oled_wr = m1_we && (addr_region(16'(m1_addr)) == REGION_OLED);

    // OLED-window writes sit out the holdoff; everything else stays eligible.
    assign m0_elig = m0_req && !(holdoff_busy && m0_oled_wr);
    assign m1_elig = m1_req && !(holdoff_busy && m1_oled_wr);

    // Arm the holdoff on the grant of an OLED-window write.
    assign holdoff_load = grant_any && ((grant_sel == SEL_M1) ? m1_oled_wr : m0_oled_wr);

    periph_arb_holdoff #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .clk  (clk),
        .rst_n(rst_n),
        .load (holdoff_load),
        .busy (holdoff_busy)
    );
`else
    assign m0_elig = m0_req;
    assign m1_elig = m1_req;
`endif

    // Round-robin pick among eligible requesters while the bus is idle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise
        // paths that skip an assignment infer a latch.
        grant_any = 1'b0;
        grant_sel = SEL_M0;
        if (rst_n && state == IDLE) begin
            if (m0_elig && m1_elig) begin
                grant_any = 1'b1;
                grant_sel = (last_gnt == SEL_M1) ? SEL_M0 : SEL_M1;
            end else if (m0_elig) begin
                grant_any = 1'b1;
                grant_sel = SEL_M0;
            end else if (m1_elig) begin
                grant_any = 1'b1;
                grant_sel = SEL_M1;
            end
        end
    end

    // Command of the master being granted, captured into the bus registers at the grant edge.
    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (grant_sel == SEL_M1) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // The grant pulse is issued in the IDLE cycle that accepts the request, so the
    // master can release req at the very next edge; it is gated by reset so it
    // stays low while rst_n is asserted.
    assign m0_gnt = grant_any && (grant_sel == SEL_M0);
    assign m1_gnt = grant_any && (grant_sel == SEL_M1);

    // Transaction FSM with registered bus strobes, done pulses and read-data registers.
    // p_write_addr/p_read_addr/p_data double as the latched command address and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_gnt     <= SEL_M1;
            cur_sel      <= SEL_M0;
            cur_we       <= 1'b0;
            m0_done      <= 1'b0;
            m1_done      <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            p_data       <= '0;
            p_write_addr <= '0;
            p_read_addr  <= '0;
            p_we         <= 1'b0;
            p_re         <= 1'b0;
            p_en         <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        state        <= ISSUE;
                        cur_sel      <= grant_sel;
                        last_gnt     <= grant_sel;
                        cur_we       <= sel_we;
                        p_en         <= 1'b1;
                        p_we         <= sel_we;
                        p_re         <= !sel_we;
                        p_write_addr <= sel_addr;
                        p_read_addr  <= sel_addr;
                        p_data       <= sel_wdata;
                    end
                end
                ISSUE: begin
                    p_en  <= 1'b0;
                    p_we  <= 1'b0;
                    p_re  <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!cur_we) begin
                        if (cur_sel == SEL_M1) begin
                            m1_rdata <= p_q;
                        end else begin
                            m0_rdata <= p_q;
                        end
                    end
                    if (cur_sel == SEL_M1) begin
                        m1_done <= 1'b1;
                    end else begin
                        m0_done <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed self-checking bench for periph_bus_arbiter. The peripheral model is a
// synchronous read port returning (read address XOR 0x6500).
// Expectations for the OLED holdoff follow PERIPH_ARB_OLED_HOLDOFF_EN.
module tb_periph_bus_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int HC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_done, m1_done;
    logic [DW-1:0] m0_rdata, m1_rdata, p_data;
    logic [AW-1:0] p_write_addr, p_read_addr;
    logic          p_we, p_re, p_en;
    logic [DW-1:0] p_q = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    periph_bus_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLDOFF_CYCLES(HC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_done(m0_done), .m1_done(m1_done),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .p_data(p_data), .p_write_addr(p_write_addr), .p_read_addr(p_read_addr),
        .p_we(p_we), .p_re(p_re), .p_en(p_en),
        .p_q(p_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: read data appears the cycle after an enabled read strobe.
    always @(posedge clk) begin
        if (p_en && p_re) p_q <= p_read_addr ^ 16'h6500;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   {m0_gnt, m1_gnt}, 0);
        check({tag, "_done"},  {m0_done, m1_done}, 0);
        check({tag, "_strb"},  {p_en, p_we, p_re}, 0);
        check({tag, "_pdata"}, p_data, 0);
        check({tag, "_pwa"},   p_write_addr, 0);
        check({tag, "_pra"},   p_read_addr, 0);
        check({tag, "_rd0"},   m0_rdata, 0);
        check({tag, "_rd1"},   m1_rdata, 0);
    endtask

    // Waits up to budget falling edges for a grant; who = 0/1, 2 if both, -1 on timeout.
    task automatic wait_any_gnt(input int budget, output int who, output int at);
        who = -1;
        at  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                who = (m0_gnt && m1_gnt) ? 2 : (m0_gnt ? 0 : 1);
                at  = cyc;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, t0, t1, t2, prev, n0, n1;
        bit  m1_seen;

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;

        // Single read by m0: gnt at T, strobes at T+1, done with data at T+3.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hC000;
        wait_any_gnt(10, who, t0);
        check("rd_gnt_who", who, 0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        check("rd_issue_strb", {p_en, p_re, p_we}, 3'b110);
        check("rd_issue_addr", p_read_addr, 16'hC000);
        @(negedge clk);
        check("rd_wait_strb", {p_en, p_re, p_we}, 3'b000);
        check("rd_wait_done", m0_done, 0);
        @(negedge clk);
        check("rd_done", {m0_done, m1_done}, 2'b10);
        check("rd_rdata", m0_rdata, 16'hA500);
        @(negedge clk);
        check("rd_done_pulse", m0_done, 0);

        // Round robin from reset: both masters read, three transactions each.
        do_reset();
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hC100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'hC200;
        prev = 0; n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            wait_any_gnt(12, who, t1);
            check($sformatf("rr_order%0d", i), who, i % 2);
            if (i > 0) check($sformatf("rr_gap%0d", i), t1 - prev, 4);
            prev = t1;
            if (who == 0) n0++;
            if (who == 1) n1++;
            @(posedge clk); #1;
            if (n0 == 3) m0_req = 1'b0;
            if (n1 == 3) m1_req = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rr_last_done", {m0_done, m1_done}, 2'b01);
        check("rr_rd0", m0_rdata, 16'hA400);
        check("rr_rd1", m1_rdata, 16'hA700);

        // m1 write; command changes after gnt are ignored, rdata untouched.
        @(posedge clk); #1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'hC450; m1_wdata = 16'h7FFF;
        wait_any_gnt(10, who, t0);
        check("wr_gnt_who", who, 1);
        @(posedge clk); #1;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0000; m1_wdata = 16'h0000;
        @(negedge clk);
        check("wr_issue_strb", {p_en, p_we, p_re}, 3'b110);
        check("wr_issue_addr", p_write_addr, 16'hC450);
        check("wr_issue_data", p_data, 16'h7FFF);
        @(negedge clk);
        check("wr_wait_strb", {p_en, p_we}, 2'b00);
        @(negedge clk);
        check("wr_done", {m0_done, m1_done}, 2'b01);
        check("wr_rdata_kept", m1_rdata, 16'hA700);

        // Reset asserted during ISSUE drops p_en immediately.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hC300;
        wait_any_gnt(10, who, t0);
        check("rsti_gnt_who", who, 0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        check("rsti_pen_before", p_en, 1);
        rst_n = 1'b0;
        #1;
        check("rsti_pen_after", p_en, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted during WAIT: everything clears, no done pulse.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hC300;
        wait_any_gnt(10, who, t0);
        check("rstw_gnt_who", who, 0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstw");
        @(negedge clk);
        check("rstw_no_done", {m0_done, m1_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First tie after reset goes to m0; m1 withdraws with no side effects.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hC000;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'hC004;
        wait_any_gnt(10, who, t0);
        check("tie_gnt_who", who, 0);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        m1_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m1_gnt || m1_done) m1_seen = 1'b1;
        end
        check("tie_m1_withdrawn", m1_seen, 0);
        check("tie_m1_rdata", m1_rdata, 0);
        check("tie_m0_rdata", m0_rdata, 16'hA500);

        // OLED write spacing: m0 OLED write, then m0 OLED write vs m1 OLED read.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'hC000; m0_wdata = 16'h1234;
        wait_any_gnt(10, who, t0);
        check("oled_first_who", who, 0);
        @(posedge clk); #1;
        m0_addr = 16'hC010; m0_wdata = 16'h5678;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'hC000;
        wait_any_gnt(12, who, t1);
        check("oled_m1_first", who, 1);
        check("oled_m1_gap", t1 - t0, 4);
        @(posedge clk); #1;
        m1_req = 1'b0;
        wait_any_gnt(30, who, t2);
        check("oled_m0_second", who, 0);
`ifdef PERIPH_ARB_OLED_HOLDOFF_EN
        check("oled_holdoff_min", (t2 - t0) >= HC, 1);
`else
        check("oled_no_holdoff", (t2 - t0) <= 8, 1);
`endif
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        check("oled_second_addr", p_write_addr, 16'hC010);
        check("oled_second_data", p_data, 16'h5678);
        repeat (2) @(negedge clk);
        check("oled_second_done", {m0_done, m1_done}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, peripheral data width; ADDR_WIDTH, 16, peripheral address width; HOLDOFF_CYCLES, 4096, OLED write spacing in clk cycles.
REQ-002 Clocking SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- m0_req/m1_req  in  1  access request, held until gnt.
- m0_we/m1_we  in  1  1=write, 0=read.
- m0_addr/m1_addr  in  ADDR_WIDTH  target address.
- m0_wdata/m1_wdata  in  DATA_WIDTH  write data.
- m0_gnt/m1_gnt  out  1  one-cycle grant pulse.
- m0_done/m1_done  out  1  one-cycle completion pulse.
- m0_rdata/m1_rdata  out  DATA_WIDTH  read data, valid with done.
- p_data  out  DATA_WIDTH  peripheral data.
- p_write_addr/p_read_addr  out  ADDR_WIDTH  peripheral addresses.
- p_we/p_re/p_en  out  1  peripheral strobes.
- p_q  in  DATA_WIDTH  peripheral read data.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; each non-IDLE state SHALL last exactly one cycle.
REQ-005 IDLE SHALL select an eligible requester, latch its we/addr/wdata, and pulse that master's gnt in the same cycle, then go to ISSUE; with no eligible requester it SHALL stay in IDLE.
REQ-006 ISSUE SHALL assert p_en=1, drive p_we=we and p_re=~we, and drive the latched address on both p_write_addr and p_read_addr and wdata on p_data; all p_* SHALL be flop outputs (glitch-free, since p_en is edge-sensitive downstream).
REQ-007 WAIT SHALL deassert p_en/p_we/p_re and register p_q into the granted master's rdata register (reads only; writes leave rdata unchanged).
REQ-008 DONE SHALL pulse the granted master's done and return to IDLE; a new grant is possible in the following IDLE cycle.
REQ-009 Latency: done SHALL assert exactly 3 cycles after the gnt cycle; peak throughput SHALL be one access per 4 cycles.
REQ-010 Arbitration SHALL be round-robin: with both eligible, grant the master not granted last; a single eligible requester SHALL always win.
REQ-011 A req dropped before gnt SHALL be treated as withdrawn, with no side effects; req/cmd changes after gnt SHALL be ignored until DONE.
REQ-012 Outputs for the non-granted master SHALL stay 0 (gnt, done); its rdata SHALL hold its last value.

Reset
REQ-013 rst_n low SHALL asynchronously force: state IDLE, all gnt/done/p_* outputs 0, both rdata 0, last-grant pointer = m1 (so m0 wins the first tie), holdoff counter 0.
REQ-014 Reset mid-transaction SHALL abort it with no done pulse; p_en SHALL fall immediately.

Configuration
REQ-015 Macro PERIPH_ARB_OLED_HOLDOFF_EN defined: a granted write with addr in the OLED window 0xC000..0xC443 SHALL load a counter with HOLDOFF_CYCLES; while it is nonzero, OLED-window writes SHALL be ineligible (not granted), and all other accesses SHALL remain eligible. The counter decrements each cycle to 0, saturating.
REQ-016 Macro undefined: no counter SHALL exist and all requests SHALL be eligible.

Structure
REQ-017 Shared package periph_arb_pkg SHALL hold the FSM state enum and the region constants OLED_LO=0xC000, OLED_HI=0xC443, LED1_LO=0xC444, LED2_LO=0xC888, REGION_END=0xCCCB.
REQ-018 The holdoff counter SHALL be the sub-module periph_arb_holdoff (load, count, busy), instantiated only under the macro.

Verification
REQ-019 m0 read 0xC000, p_q model returns 0xA500 -> m0_gnt at T, p_en=1/p_re=1 at T+1, m0_done with m0_rdata=0xA500 at T+3.
REQ-020 m0 and m1 request reads together from reset, held for 3 transactions each -> grant order m0, m1, m0, m1, m0, m1, with gnt pulses 4 cycles apart.
REQ-021 m1 write 0xC450 data 0x7FFF -> p_we=1, p_write_addr=0xC450, p_data=0x7FFF for one cycle; m1_done at +3; m1_rdata unchanged.
REQ-022 rst_n low during WAIT -> all outputs 0 asynchronously, no done pulse; after release, the first tie grants m0.
REQ-023 Macro on, HOLDOFF_CYCLES=16: m0 write 0xC000, then m0 write 0xC010 and m1 read 0xC000 -> m1 granted first; m0's second write gnt not before 16 cycles after the first gnt.
REQ-024 Macro off, same stimulus as REQ-023 -> m0's second write granted within 8 cycles of the first gnt.
